if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the byte address of the first fetch after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction inserted into IF/ID.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port stall  input  1  hazard unit request to hold PC and IF/ID.
REQ-006 SHALL have port flush  input  1  request to replace the IF/ID contents with a bubble.
REQ-007 SHALL have port jump_en  input  1  redirect request from EX (branch taken / jal / jalr).
REQ-008 SHALL have port jump_target  input  32  redirect byte address.
REQ-009 SHALL have port im_addr  output  32  byte address to the instruction memory (word index formed downstream).
REQ-010 SHALL have port im_dout  input  32  instruction word, valid combinationally in the same cycle as im_addr.
REQ-011 SHALL have port pc_if  output  32  current PC.
REQ-012 SHALL have ports pc_id, pc4_id, inst_id  output  32 each  IF/ID register contents: PC, PC+4, instruction.
REQ-013 SHALL have port valid_id  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port misalign_fault  output  1  sticky flag, redirect target had bits [1:0] nonzero.
REQ-015 SHALL have port fetch_cnt  output  32  valid-fetch counter (see Configuration).

Function
REQ-016 SHALL drive im_addr and pc_if combinationally from the PC register; no added latency.
REQ-017 SHALL compute next PC with priority: jump_en -> {jump_target[31:2],2'b00}; else stall -> hold; else PC+4.
REQ-018 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); pc4_id wraps identically.
REQ-019 SHALL update IF/ID with priority: jump_en or flush -> bubble; else stall -> hold; else capture {pc_if, pc_if+4, im_dout}, valid_id=1.
REQ-020 SHALL define bubble as inst_id=NOP_INST, pc_id=0, pc4_id=0, valid_id=0.
REQ-021 SHALL apply jump_en over stall in the same cycle (redirect never lost); flush with stall yields a bubble and held PC.
REQ-022 SHALL set misalign_fault on any edge where jump_en=1 and jump_target[1:0]!=0; only reset clears it.
REQ-023 SHALL present the instruction at PC_RESET in IF/ID (valid_id=1) one cycle after rstn deasserts, absent stall/flush/jump.
REQ-024 SHALL ignore jump_target when jump_en=0.

Reset
REQ-025 SHALL, while rstn=0, force PC=PC_RESET, IF/ID=bubble, misalign_fault=0, fetch_cnt=0, asynchronously.
REQ-026 SHALL, on reset mid-operation, discard any pending redirect, stall or flush; no state survives.
REQ-027 SHALL begin normal update on the first rising clk edge after rstn rises.

Configuration
REQ-028 SHALL, with macro IF_STAGE_FETCH_CNT_EN defined, increment fetch_cnt by 1 (wrapping at 2^32) on each edge where IF/ID captures a valid instruction per REQ-019.
REQ-029 SHALL, without IF_STAGE_FETCH_CNT_EN, keep the fetch_cnt port and tie it to constant 0 with no counter logic.

Verification
REQ-030 Reset release, no stimulus, im_dout=mem[PC] -> im_addr 0x3000, 0x3004, 0x3008 on successive cycles; inst_id/pc_id follow one cycle later, valid_id=1.
REQ-031 stall=1 for 3 cycles at PC=0x3008 -> im_addr, pc_id, inst_id constant for all 3 cycles; 0x300C fetched on the first cycle after stall drops.
REQ-032 jump_en=1, jump_target=0x3040, stall=1, same cycle -> next im_addr=0x3040, valid_id=0, inst_id=0x00000013.
REQ-033 jump_en=1, jump_target=0x3042 -> next im_addr=0x3040, misalign_fault=1, stays 1 through later jumps until rstn=0.
REQ-034 Force PC to 0xFFFFFFFC via jump -> next im_addr=0x00000000; pc4_id of that fetch = 0x00000000.
REQ-035 rstn pulled low mid-stream with jump_en=1 -> immediate PC=0x3000, valid_id=0, fetch_cnt=0; with IF_STAGE_FETCH_CNT_EN, 10 unstalled cycles after release -> fetch_cnt=10.

Source files
------------

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if -- instruction-memory fetch bus between the fetch stage and the
// instruction memory.
//
// Signals:
//   im_addr  fetch byte address, driven by the fetch stage
//   im_dout  instruction word, returned combinationally by the memory
//
// Modports:
//   master   fetch-stage side (drives im_addr, reads im_dout)
//   slave    memory side      (reads im_addr, drives im_dout)
// -----------------------------------------------------------------------------
interface if_stage_if;
    logic [31:0] im_addr;
    logic [31:0] im_dout;

    modport master (output im_addr, input  im_dout);
    modport slave  (input  im_addr, output im_dout);
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with PC register and IF/ID pipeline
// register.
//
// Parameters:
//   PC_RESET   byte address of the first fetch after reset
//   NOP_INST   bubble instruction placed in IF/ID
//
// Ports:
//   clk             system clock, rising edge
//   rstn            asynchronous active-low reset
//   stall           hold PC and IF/ID
//   flush           replace IF/ID with a bubble
//   jump_en         redirect request from EX
//   jump_target     redirect byte address (low two bits dropped)
//   imem            instruction-memory bus (master side)
//   pc_if           current PC
//   pc_id           IF/ID PC
//   pc4_id          IF/ID PC+4
//   inst_id         IF/ID instruction
//   valid_id        IF/ID holds a real instruction
//   misalign_fault  sticky: a redirect target had bits [1:0] nonzero
//   fetch_cnt       valid-fetch counter
//
// Configuration macro:
//   IF_STAGE_FETCH_CNT_EN  when defined, fetch_cnt counts IF/ID captures of
//                          valid instructions; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  logic              jump_en,
    input  logic [31:0]       jump_target,
    if_stage_if.master        imem,
    output logic [31:0]       pc_if,
    output logic [31:0]       pc_id,
    output logic [31:0]       pc4_id,
    output logic [31:0]       inst_id,
    output logic              valid_id,
    output logic              misalign_fault,
    output logic [31:0]       fetch_cnt
);

    logic [31:0] pc_q,     pc_d;
    logic [31:0] pc_id_q,  pc_id_d;
    logic [31:0] pc4_id_q, pc4_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;
    logic        misalign_q, misalign_d;

    // Natural 32-bit overflow gives the required wrap from 0xFFFF_FFFC to 0.
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    // A redirect or flush kills whatever is in IF/ID; a redirect also beats a
    // stall so it is never lost.
    logic kill_ifid;
    assign kill_ifid = jump_en | flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        pc_d       = pc_plus4;
        pc_id_d    = pc_id_q;
        pc4_id_d   = pc4_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        misalign_d = misalign_q;

        if (jump_en) begin
            pc_d = {jump_target[31:2], 2'b00};
            if (jump_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall) begin
            pc_d = pc_q;
        end

        if (kill_ifid) begin
            pc_id_d    = '0;
            pc4_id_d   = '0;
            inst_id_d  = NOP_INST;
            valid_id_d = 1'b0;
        end else if (!stall) begin
            pc_id_d    = pc_q;
            pc4_id_d   = pc_plus4;
            inst_id_d  = imem.im_dout;
            valid_id_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= PC_RESET;
            pc_id_q    <= '0;
            pc4_id_q   <= '0;
            inst_id_q  <= NOP_INST;
            valid_id_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            pc4_id_q   <= pc4_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef IF_STAGE_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        capture;

    // Same condition under which IF/ID loads a valid instruction.
    assign capture     = !kill_ifid && !stall;
    assign fetch_cnt_d = capture ? fetch_cnt_q + 32'd1 : fetch_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    assign fetch_cnt = '0;
`endif

    assign imem.im_addr   = pc_q;
    assign pc_if          = pc_q;
    assign pc_id          = pc_id_q;
    assign pc4_id         = pc4_id_q;
    assign inst_id        = inst_id_q;
    assign valid_id       = valid_id_q;
    assign misalign_fault = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A transaction-level model tracks the expected PC, IF/ID contents, sticky
// fault and fetch count; a compare process checks every DUT output against it
// on each falling clock edge. Directed steps add literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_if_stage;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'h1234_5677; // junk, must be ignored
    logic [31:0] pc_if, pc_id, pc4_id, inst_id, fetch_cnt;
    logic        valid_id, misalign_fault;

    int n_cmp = 0;
    int n_err = 0;

    if_stage_if imb ();

    if_stage #(.PC_RESET(PC_RESET), .NOP_INST(NOP_INST)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall          (stall),
        .flush          (flush),
        .jump_en        (jump_en),
        .jump_target    (jump_target),
        .imem           (imb.master),
        .pc_if          (pc_if),
        .pc_id          (pc_id),
        .pc4_id         (pc4_id),
        .inst_id        (inst_id),
        .valid_id       (valid_id),
        .misalign_fault (misalign_fault),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory content: a recognisable function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imb.im_dout = mem_word(imb.im_addr);

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{pc: 32'd0, pc4: 32'd0, inst: NOP_INST, valid: 1'b0};

    logic [31:0] m_pc    = PC_RESET;
    ifid_t       m_ifid  = BUBBLE;
    logic        m_fault = 1'b0;
    logic [31:0] m_cnt   = 32'd0;
    logic [31:0] m_cur;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pc    = PC_RESET;
            m_ifid  = BUBBLE;
            m_fault = 1'b0;
            m_cnt   = 32'd0;
        end else begin
            m_cur = m_pc;
            if (jump_en || flush) begin
                m_ifid = BUBBLE;
            end else if (!stall) begin
                m_ifid = '{pc: m_cur, pc4: m_cur + 32'd4, inst: mem_word(m_cur), valid: 1'b1};
                m_cnt  = m_cnt + 32'd1;
            end
            if (jump_en) begin
                m_pc = jump_target & ~32'd3;
                if (jump_target % 4 != 0) m_fault = 1'b1;
            end else if (!stall) begin
                m_pc = m_cur + 32'd4;
            end
        end
    end

    function automatic logic [31:0] exp_cnt();
`ifdef IF_STAGE_FETCH_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- cycle-by-cycle compare ----------------
    bit done = 1'b0;

    initial begin
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            check("model im_addr",  imb.im_addr, m_pc);
            check("model pc_if",    pc_if,       m_pc);
            check("model pc_id",    pc_id,       m_ifid.pc);
            check("model pc4_id",   pc4_id,      m_ifid.pc4);
            check("model inst_id",  inst_id,     m_ifid.inst);
            check("model valid_id", {31'd0, valid_id}, {31'd0, m_ifid.valid});
            check("model misalign", {31'd0, misalign_fault}, {31'd0, m_fault});
            check("model fetch_cnt", fetch_cnt,  exp_cnt());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        check("rst im_addr",  imb.im_addr, 32'h0000_3000);
        check("rst valid",    {31'd0, valid_id}, 32'd0);
        check("rst inst",     inst_id, 32'h0000_0013);
        check("rst pc_id",    pc_id, 32'd0);
        check("rst fetch_cnt", fetch_cnt, 32'd0);
        check("rst misalign", {31'd0, misalign_fault}, 32'd0);

        rstn = 1'b1;
        cyc();
        check("seq im_addr 1", imb.im_addr, 32'h0000_3004);
        check("seq pc_id 1",   pc_id, 32'h0000_3000);
        check("seq inst 1",    inst_id, 32'hDEAD_3000);
        check("seq valid 1",   {31'd0, valid_id}, 32'd1);
        cyc();
        check("seq im_addr 2", imb.im_addr, 32'h0000_3008);
        check("seq pc_id 2",   pc_id, 32'h0000_3004);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall im_addr", imb.im_addr, 32'h0000_3008);
            check("stall pc_id",   pc_id, 32'h0000_3004);
            check("stall inst",    inst_id, 32'hDEAD_3004);
        end
        stall = 1'b0;
        cyc();
        check("unstall im_addr", imb.im_addr, 32'h0000_300C);
        check("unstall pc_id",   pc_id, 32'h0000_3008);
        cyc();
        check("unstall pc_id 2", pc_id, 32'h0000_300C);
        check("no-jump misalign", {31'd0, misalign_fault}, 32'd0);

        jump_en = 1'b1; jump_target = 32'h0000_3040; stall = 1'b1;
        cyc();
        check("jmp+stall im_addr", imb.im_addr, 32'h0000_3040);
        check("jmp+stall valid",   {31'd0, valid_id}, 32'd0);
        check("jmp+stall inst",    inst_id, 32'h0000_0013);
        jump_en = 1'b0; stall = 1'b0; jump_target = 32'hFFFF_FFFF;
        cyc();
        check("post-jmp pc_id", pc_id, 32'h0000_3040);
        check("post-jmp valid", {31'd0, valid_id}, 32'd1);

        flush = 1'b1; stall = 1'b1;
        cyc();
        check("flush+stall im_addr", imb.im_addr, 32'h0000_3044);
        check("flush+stall valid",   {31'd0, valid_id}, 32'd0);
        stall = 1'b0;
        cyc();
        check("flush im_addr", imb.im_addr, 32'h0000_3048);
        flush = 1'b0;
        cyc();
        check("post-flush pc_id", pc_id, 32'h0000_3048);

        jump_en = 1'b1; jump_target = 32'h0000_3042;
        cyc();
        check("misalign im_addr", imb.im_addr, 32'h0000_3040);
        check("misalign set",     {31'd0, misalign_fault}, 32'd1);
        jump_target = 32'h0000_3080;
        cyc();
        check("aligned im_addr", imb.im_addr, 32'h0000_3080);
        check("misalign sticky", {31'd0, misalign_fault}, 32'd1);

        jump_target = 32'hFFFF_FFFC;
        cyc();
        check("top im_addr", imb.im_addr, 32'hFFFF_FFFC);
        jump_en = 1'b0;
        cyc();
        check("wrap im_addr", imb.im_addr, 32'h0000_0000);
        check("wrap pc_id",   pc_id, 32'hFFFF_FFFC);
        check("wrap pc4_id",  pc4_id, 32'h0000_0000);
        cyc();
        check("wrap2 pc4_id", pc4_id, 32'h0000_0004);

        jump_en = 1'b1; jump_target = 32'h0000_3100;
        #2;
        rstn = 1'b0;
        #1;
        check("arst im_addr",  imb.im_addr, 32'h0000_3000);
        check("arst valid",    {31'd0, valid_id}, 32'd0);
        check("arst fetch_cnt", fetch_cnt, 32'd0);
        check("arst misalign", {31'd0, misalign_fault}, 32'd0);
        cyc();
        check("arst hold im_addr", imb.im_addr, 32'h0000_3000);
        jump_en = 1'b0;
        rstn = 1'b1;
        repeat (10) cyc();
        check("run im_addr", imb.im_addr, 32'h0000_3028);
`ifdef IF_STAGE_FETCH_CNT_EN
        check("run fetch_cnt", fetch_cnt, 32'd10);
`else
        check("run fetch_cnt", fetch_cnt, 32'd0);
`endif

        done = 1'b1;
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
